// File: rtl/led_panel_scan_ctrl.sv
// Row-scan sequencer for a single-colour-bit RGB LED panel.
// Fetches one row of pixels from a framebuffer read port, shifts it into the
// column drivers, latches it, advances the external row counter and lights
// the row for a fixed on-time. All outputs are registered so the pins are
// glitch-free; the output registers are loaded from the next-state values so
// each output reflects the state of the cycle in which it is seen.
module led_panel_scan_ctrl #(
    parameter int COLS      = 32,
    parameter int ROWS      = 8,
    parameter int ON_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            fb_rd,
    output logic [$clog2(ROWS*COLS)-1:0]    fb_addr,
    input  logic [2:0]                      fb_rgb,
    output logic                            red_out,
    output logic                            green_out,
    output logic                            blue_out,
    output logic                            sclk_out,
    output logic                            latch_out,
    output logic                            blank_out,
    output logic                            aclk_out,
    output logic                            arst_out,
    output logic [$clog2(ROWS)-1:0]         row,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int AW        = RW + CW;
    localparam int SHIFT_LEN = 2 + 2 * COLS;
    localparam int CNT_MAX   = (SHIFT_LEN > ON_CYCLES) ? SHIFT_LEN : ON_CYCLES;
    localparam int CNTW      = $clog2(CNT_MAX + 1);

    // Shift-phase cycle index k: k=0 and k=1 are lead-in, column c uses
    // k=2+2c (sclk low) and k=3+2c (sclk high).
    localparam logic [CNTW-1:0] SHIFT_LAST = CNTW'(SHIFT_LEN - 1);
    localparam logic [CNTW-1:0] SHOW_LAST  = CNTW'(ON_CYCLES - 1);
    localparam logic [CNTW-1:0] RD_LIMIT   = CNTW'(2 * COLS);
    localparam logic [CNTW-1:0] K_TWO      = CNTW'(2);
    localparam logic [CNTW-1:0] K_ONE      = CNTW'(1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [RW-1:0]   ROW_ONE    = RW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARST  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_nx;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_nx;
    logic [RW-1:0]   row_nx;
    logic [CW-1:0]   col_nx;
    logic            rd_d_r;

    logic            fb_rd_nx;
    logic [AW-1:0]   fb_addr_nx;
    logic            sclk_nx;
    logic            latch_nx;
    logic            blank_nx;
    logic            aclk_nx;
    logic            arst_nx;
    logic            frame_done_nx;
    logic            busy_nx;
    logic            rgb_clr_nx;

    // Next-state, phase counter and row index sequencing.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        row_nx   = row;
        case (state_r)
            ST_IDLE: begin
                cnt_nx = '0;
                row_nx = '0;
                if (enable) begin
                    state_nx = ST_ARST;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ARST: begin
                state_nx = ST_SHIFT;
                cnt_nx   = '0;
                row_nx   = '0;
            end
            ST_SHIFT: begin
                if (cnt_r == SHIFT_LAST) begin
                    state_nx = ST_LATCH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_r + K_ONE;
                end
            end
            ST_LATCH: begin
                state_nx = ST_SHOW;
                cnt_nx   = '0;
            end
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_nx = ST_NEXT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_r + K_ONE;
                end
            end
            ST_NEXT: begin
                cnt_nx = '0;
                if (enable) begin
                    state_nx = ST_SHIFT;
                    if (row == ROW_LAST) begin
                        row_nx = '0;
                    end else begin
                        row_nx = row + ROW_ONE;
                    end
                end else begin
                    // Leaving to IDLE parks the row index at 0.
                    state_nx = ST_IDLE;
                    row_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                row_nx   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state.
    always_comb begin
        fb_rd_nx      = 1'b0;
        fb_addr_nx    = '0;
        sclk_nx       = 1'b0;
        latch_nx      = 1'b0;
        blank_nx      = 1'b1;
        aclk_nx       = 1'b0;
        arst_nx       = 1'b0;
        frame_done_nx = 1'b0;
        rgb_clr_nx    = 1'b0;
        busy_nx       = (state_nx != ST_IDLE);
        // k>>1 gives column 0 for the lead-in read and c+1 in phase L of c.
        col_nx        = cnt_nx[CW:1];
        case (state_nx)
            ST_IDLE: begin
                rgb_clr_nx = 1'b1;
            end
            ST_ARST: begin
                arst_nx    = 1'b1;
                rgb_clr_nx = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_nx == '0) begin
                    fb_rd_nx = 1'b1;
                end else if (cnt_nx >= K_TWO) begin
                    if (cnt_nx[0]) begin
                        sclk_nx = 1'b1;
                    end else if (cnt_nx < RD_LIMIT) begin
                        fb_rd_nx = 1'b1;
                    end else begin
                        fb_rd_nx = 1'b0;
                    end
                end else begin
                    fb_rd_nx = 1'b0;
                end
                if (fb_rd_nx) begin
                    fb_addr_nx = {row_nx, col_nx};
                end else begin
                    fb_addr_nx = '0;
                end
            end
            ST_LATCH: begin
                latch_nx   = 1'b1;
                rgb_clr_nx = 1'b1;
            end
            ST_SHOW: begin
                blank_nx = 1'b0;
            end
            ST_NEXT: begin
                if (row_nx == ROW_LAST) begin
                    arst_nx       = 1'b1;
                    frame_done_nx = 1'b1;
                end else begin
                    aclk_nx = 1'b1;
                end
            end
            default: begin
                blank_nx = 1'b1;
            end
        endcase
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            row        <= '0;
            rd_d_r     <= 1'b0;
            fb_rd      <= 1'b0;
            fb_addr    <= '0;
            sclk_out   <= 1'b0;
            latch_out  <= 1'b0;
            blank_out  <= 1'b1;
            aclk_out   <= 1'b0;
            arst_out   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            row        <= row_nx;
            rd_d_r     <= fb_rd;
            fb_rd      <= fb_rd_nx;
            fb_addr    <= fb_addr_nx;
            sclk_out   <= sclk_nx;
            latch_out  <= latch_nx;
            blank_out  <= blank_nx;
            aclk_out   <= aclk_nx;
            arst_out   <= arst_nx;
            frame_done <= frame_done_nx;
            busy       <= busy_nx;
        end
    end

    // Column data: capture the pixel the cycle after each read so it
    // appears at the start of the following sclk-low phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_out   <= 1'b0;
            green_out <= 1'b0;
            blue_out  <= 1'b0;
        end else if (rgb_clr_nx) begin
            red_out   <= 1'b0;
            green_out <= 1'b0;
            blue_out  <= 1'b0;
        end else if (rd_d_r) begin
            red_out   <= fb_rgb[2];
            green_out <= fb_rgb[1];
            blue_out  <= fb_rgb[0];
        end else begin
            red_out   <= red_out;
            green_out <= green_out;
            blue_out  <= blue_out;
        end
    end

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Self-checking bench for led_panel_scan_ctrl (COLS=4, ROWS=4, ON_CYCLES=8).
// A framebuffer model returns addr[2:0]; expected pixels are queued when a
// read is issued and compared when the column clock rises.
module tb_led_panel_scan_ctrl;

    localparam logic [16:0] IDLE_VEC = 17'h00040;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fb_rd;
    logic [3:0] fb_addr;
    logic [2:0] fb_rgb = 3'd0;
    logic       red_out, green_out, blue_out;
    logic       sclk_out, latch_out, blank_out, aclk_out, arst_out;
    logic [1:0] row;
    logic       frame_done, busy;

    int test_cnt = 0;
    int fail_cnt = 0;

    led_panel_scan_ctrl #(.COLS(4), .ROWS(4), .ON_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_rgb(fb_rgb),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
        .aclk_out(aclk_out), .arst_out(arst_out), .row(row),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Framebuffer: data valid the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (fb_rd === 1'b1) fb_rgb <= fb_addr[2:0];
        else fb_rgb <= 3'($urandom_range(0, 7));
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] outs_vec();
        return {fb_rd, fb_addr, red_out, green_out, blue_out, sclk_out, latch_out,
                blank_out, aclk_out, arst_out, row, frame_done, busy};
    endfunction

    // Scoreboard and monitor state.
    logic [2:0] exp_q[$];
    logic [2:0] exp_pix;
    logic [3:0] exp_addr = 4'd0;
    int cyc = 0, bnd_cyc = 0, last_sclk = 0, last_fd = -1;
    int sclk_cnt = 0, aclk_cnt = 0, blank_low = 0, latch_cnt = 0, fd_cnt = 0;
    logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_blank = 1'b1;
    logic [2:0] prev_rgb = 3'd0;

    // Per-cycle monitor: invariants, pixel scoreboard and timing relations.
    always @(negedge clk) begin
        cyc++;
        check_val("pulse_onehot", 32'($countones({latch_out, aclk_out, arst_out, sclk_out}) <= 1), 32'd1);
        if (latch_out | aclk_out | arst_out) check_val("blank_on_pulse", 32'(blank_out), 32'd1);
        if (!busy) begin
            check_val("idle_vals", 32'(outs_vec()), 32'(IDLE_VEC));
            exp_q.delete();
            exp_addr = 4'd0; sclk_cnt = 0; aclk_cnt = 0; last_fd = -1;
        end
        if (fb_rd) begin
            check_val("fb_addr", 32'(fb_addr), 32'(exp_addr));
            exp_q.push_back(exp_addr[2:0]);
            exp_addr = exp_addr + 4'd1;
        end
        if (sclk_out) begin
            if (sclk_cnt == 0) check_val("sclk_first_gap", 32'(cyc - bnd_cyc), 32'd4);
            else check_val("sclk_gap", 32'(cyc - last_sclk), 32'd2);
            check_val("rgb_stable", 32'({red_out, green_out, blue_out}), 32'(prev_rgb));
            if (exp_q.size() == 0) begin
                check_val("rgb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_pix = exp_q.pop_front();
                check_val("rgb_data", 32'({red_out, green_out, blue_out}), 32'(exp_pix));
            end
            sclk_cnt++;
            last_sclk = cyc;
        end
        if (latch_out) begin
            check_val("latch_sclk_cnt", 32'(sclk_cnt), 32'd4);
            check_val("latch_after_sclk", 32'(prev_sclk), 32'd1);
            check_val("latch_rgb_clr", 32'({red_out, green_out, blue_out}), 32'd0);
            check_val("latch_q_empty", 32'(exp_q.size()), 32'd0);
            check_val("latch_row", 32'(row), 32'(aclk_cnt));
            sclk_cnt = 0;
            latch_cnt++;
        end
        if (!blank_out) begin
            if (prev_blank) check_val("blank_fall_after_latch", 32'(prev_latch), 32'd1);
            blank_low++;
        end else if (!prev_blank) begin
            check_val("show_len", 32'(blank_low), 32'd8);
            blank_low = 0;
        end
        if (aclk_out) begin
            check_val("aclk_no_fd", 32'(frame_done), 32'd0);
            aclk_cnt++;
            bnd_cyc = cyc;
        end
        if (frame_done) begin
            check_val("fd_with_arst", 32'(arst_out), 32'd1);
            check_val("fd_aclk_cnt", 32'(aclk_cnt), 32'd3);
            if (last_fd >= 0) check_val("fd_period", 32'(cyc - last_fd), 32'd80);
            last_fd = cyc;
            aclk_cnt = 0;
            fd_cnt++;
        end
        if (arst_out) begin
            check_val("arst_addr_wrap", 32'(exp_addr), 32'd0);
            bnd_cyc = cyc;
        end
        prev_sclk  = sclk_out;
        prev_latch = latch_out;
        prev_blank = blank_out;
        prev_rgb   = {red_out, green_out, blue_out};
    end

    task automatic wait_fd(input int n, input int budget, input string tag);
        int start;
        int k;
        start = fd_cnt;
        k = 0;
        while ((fd_cnt - start) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'((fd_cnt - start) >= n), 32'd1);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: sequence still running, expected finish");
        $fatal(1);
    end

    // Directed sequence.
    initial begin
        int k;
        int lc0;
        reset  = 1'b1;
        enable = 1'b1;
        // Reset held three cycles with enable high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_vals", 32'(outs_vec()), 32'(IDLE_VEC));
        end
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_arst", 32'(arst_out), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("rst_arst_1cyc", 32'(arst_out), 32'd0);
        check_val("first_read", 32'({fb_rd, fb_addr}), 32'h10);

        // Two full frames of normal scanning.
        wait_fd(2, 400, "frames_run");

        // Drop enable during SHOW of row 2.
        k = 0;
        while (!(row == 2'd2 && blank_out == 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("drop_reach_show", 32'(row == 2'd2 && blank_out == 1'b0), 32'd1);
        enable = 1'b0;
        k = 0;
        @(negedge clk);
        while (aclk_out !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val("drop_next_aclk", 32'(aclk_out), 32'd1);
        check_val("drop_next_blank", 32'(blank_out), 32'd1);
        @(negedge clk);
        check_val("drop_idle", 32'(outs_vec()), 32'(IDLE_VEC));
        repeat (3) @(negedge clk);
        check_val("drop_stay_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check_val("reen_arst", 32'(arst_out), 32'd1);
        @(negedge clk);
        check_val("reen_addr0", 32'({fb_rd, fb_addr}), 32'h10);

        // Reset during the fifth SHIFT cycle.
        lc0 = latch_cnt;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_vals", 32'(outs_vec()), 32'(IDLE_VEC));
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_arst", 32'(arst_out), 32'd1);
        check_val("midrst_nolatch", 32'(latch_cnt - lc0), 32'd0);
        wait_fd(1, 200, "midrst_resume");

        // Random enable toggling; the monitor checks invariants every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
        wait_fd(2, 500, "random_resume");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/led_panel_scan_ctrl.md
# led_panel_scan_ctrl

Row-scan sequencer for the single-colour-bit RGB LED panel driver. It fetches each row's pixel bits from a framebuffer read port and shifts them into the panel column drivers on `sclk_out`. It then latches the row, drives the external row counter via `aclk_out`/`arst_out`, and gates `blank_out` so each row is lit for a fixed on-time. It sits between the framebuffer and the panel output pins, replacing free-running pattern logic inside the panel driver.

## Interface

Parameters:

- `COLS`, default 32: columns per row; power of two, ≥2.
- `ROWS`, default 8: rows per frame; power of two, 2..256.
- `ON_CYCLES`, default 64: clk cycles a row is displayed; ≥1.

Ports:

- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high; dominates all other inputs.
- `enable` input 1: level; run scanning while high.
- `fb_rd` output 1: framebuffer read strobe.
- `fb_addr` output log2(ROWS*COLS): read address = {row, col}.
- `fb_rgb` input 3: {r,g,b} pixel; valid the cycle after `fb_rd`.
- `red_out`, `green_out`, `blue_out` output 1 each: column serial data.
- `sclk_out` output 1: column shift clock.
- `latch_out` output 1: column latch pulse.
- `blank_out` output 1: high = panel dark.
- `aclk_out` output 1: row counter advance pulse.
- `arst_out` output 1: row counter reset pulse.
- `row` output log2(ROWS): row currently being shifted/shown.
- `frame_done` output 1: one-cycle pulse at end of last row.
- `busy` output 1: high in every state except IDLE.

## Operation

- All outputs are registered.
- Reset values:
  - state IDLE, `row`=0, column counter 0, `blank_out`=1.
  - All other outputs 0, including `fb_addr`.
- IDLE:
  - `blank_out`=1, all other outputs 0.
  - `enable`=1 sampled → ARST.
- ARST (1 cycle):
  - `arst_out`=1, `blank_out`=1, `row`←0.
  - → SHIFT.
- SHIFT (2+2·COLS cycles, `blank_out`=1):
  - Lead-in cycles s0, s1: `sclk_out`=0; `fb_rd`=1 with addr {row,0} in s0.
  - Column c occupies phase L at cycle 2+2c (`sclk_out`=0) and phase H at cycle 3+2c (`sclk_out`=1).
  - rgb outputs change only at the start of phase L and stay stable through phase H.
  - In phase L of column c, if c<COLS−1: `fb_rd`=1, `fb_addr`={row,c+1}. `fb_rd` is 0 in all other cycles.
  - `fb_rgb` is registered onto rgb outputs at the end of the cycle after each `fb_rd`.
  - Column 0 is shifted first. → LATCH after phase H of column COLS−1.
- LATCH (1 cycle):
  - `latch_out`=1, `blank_out`=1, rgb outputs cleared to 0.
  - → SHOW.
- SHOW (ON_CYCLES cycles):
  - `blank_out`=0, all other pulses 0.
  - → NEXT.
- NEXT (1 cycle, `blank_out`=1):
  - If `row`=ROWS−1: `arst_out`=1, `frame_done`=1, `row`←0.
  - Else: `aclk_out`=1, `row`←row+1.
  - Then `enable`=1 → SHIFT; `enable`=0 → IDLE.
- `enable` deasserted mid-row: the current row completes through NEXT, then IDLE.
- Re-enable from IDLE always passes through ARST, so the external counter and `row` restart at 0.
- `enable` is only sampled in IDLE and NEXT.
- At most one of `latch_out`/`aclk_out`/`arst_out`/`sclk_out` is high in any cycle.
- `blank_out` is high in every cycle where `latch_out`, `aclk_out` or `arst_out` is high.

## Timing

- IDLE→ARST: `arst_out` high the cycle after `enable` is first sampled high.
- Row period, NEXT to NEXT: 2·COLS + ON_CYCLES + 4 cycles (132 with defaults).
- Frame period: ROWS × row period.
- First `sclk_out` rise is 4 cycles after ARST.
- `latch_out` is the cycle after the last `sclk_out`=1.
- `blank_out` falls the cycle after `latch_out`.
- Read latency assumed exactly 1 cycle; no backpressure.
- `reset` asserted in any state: the next cycle shows reset values. `blank_out` is high immediately; no partial latch or pulse is emitted.

## Test plan

Default bench parameters: COLS=4, ROWS=4, ON_CYCLES=8. Framebuffer model returns `fb_rgb` = addr[2:0].

- **Reset**
  - Stimulus: hold `reset` 3 cycles with `enable`=1.
  - Required: `blank_out`=1, all other outputs 0, `busy`=0 throughout.
  - After release: `arst_out` pulses exactly 1 cycle later.
- **Row 0 shift**
  - Required: 4 `sclk_out` pulses, 2 cycles apart.
  - rgb sampled at each `sclk_out` rise = 3'b000, 001, 010, 011.
  - `fb_addr` sequence 0,1,2,3, each with 1-cycle `fb_rd`.
  - `latch_out` the following cycle, then `blank_out`=0 for exactly 8 cycles.
- **Row advance**
  - Required: NEXT emits `aclk_out` for rows 0..2.
  - Row 3 emits `arst_out` + `frame_done` together.
  - `frame_done` recurs every 80 cycles.
  - Row 1 shifts addresses 4..7.
- **Enable drop**
  - Stimulus: `enable`→0 during SHOW of row 2.
  - Required: NEXT still pulses `aclk_out`, then IDLE with `blank_out`=1.
  - On re-enable: `arst_out`, then shifting restarts at `fb_addr`=0.
- **Mid-SHIFT reset**
  - Stimulus: `reset` in cycle 5 of SHIFT.
  - Required: no `latch_out`; reset values the next cycle.
  - Normal frame resumes after release.
- **Invariants**
  - Checked every cycle with random `enable` toggling: at most one pulse output is high.
  - `blank_out` is high whenever `latch_out`, `aclk_out` or `arst_out` is high.
